// File: rtl/tron_pkg.sv
// rtl/tron_pkg.sv - shared screen geometry, colours, requester indices and position-field helpers
package tron_pkg;

    localparam int SCREEN_W_DEF = 160;
    localparam int SCREEN_H_DEF = 120;
    localparam int TIMER_Y_DEF  = 119;

    localparam int N_REQ = 5;

    localparam logic [2:0] REQ_P1    = 3'd0;
    localparam logic [2:0] REQ_P2    = 3'd1;
    localparam logic [2:0] REQ_P3    = 3'd2;
    localparam logic [2:0] REQ_P4    = 3'd3;
    localparam logic [2:0] REQ_TIMER = 3'd4;

    localparam logic [2:0] COL_P1    = 3'b001;
    localparam logic [2:0] COL_P2    = 3'b010;
    localparam logic [2:0] COL_P3    = 3'b100;
    localparam logic [2:0] COL_P4    = 3'b110;
    localparam logic [2:0] COL_TIMER = 3'b111;
    localparam logic [2:0] COL_BLACK = 3'b000;

    localparam int X_MSB = 14;
    localparam int X_LSB = 7;
    localparam int Y_MSB = 6;

    typedef enum logic {
        ST_ARB,
        ST_CLEAR
    } plot_state_e;

    function automatic logic [7:0] pos_x(input logic [14:0] pos);
        return pos[X_MSB:X_LSB];
    endfunction

    function automatic logic [6:0] pos_y(input logic [14:0] pos);
        return pos[Y_MSB:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with rotating priority pointer
module rr_arbiter
    import tron_pkg::*;
#(
    parameter int N = N_REQ
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 advance,
    output logic                 win_valid,
    output logic [$clog2(N)-1:0] win_idx
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] ptr_q;
    logic [IW-1:0] ptr_d;

    // Pick the first requester at or after the pointer, wrapping past N-1; lowest offset wins
    always_comb begin
        int cand;
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[cand]) begin
                win_valid = 1'b1;
                win_idx   = IW'(cand);
            end
        end
    end

    // Pointer moves just past the winner only when the caller consumes the grant
    always_comb begin
        ptr_d = ptr_q;
        if (advance && win_valid) begin
            ptr_d = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/plot_scheduler.sv
// rtl/plot_scheduler.sv - shares the VGA plot port among player heads, timer bar and clear sweep
module plot_scheduler
    import tron_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF,
    parameter int TIMER_Y  = TIMER_Y_DEF
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        clear_req,
    input  logic [4:0]  req,
    input  logic [14:0] p1,
    input  logic [14:0] p2,
    input  logic [14:0] p3,
    input  logic [14:0] p4,
    input  logic [7:0]  timer_x,
    output logic [4:0]  grant,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot,
    output logic        clear_busy,
    output logic        dropped
);

    localparam logic [7:0] X_LAST  = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST  = 7'(SCREEN_H - 1);
    localparam logic [6:0] TIMER_R = 7'(TIMER_Y);

    plot_state_e state_q, state_d;
    logic [7:0]  sx_q, sx_d;
    logic [6:0]  sy_q, sy_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;
    logic [4:0]  grant_q, grant_d;
    logic        busy_q, busy_d;
    logic        dropped_q, dropped_d;

    logic        arb_advance;
    logic        win_valid;
    logic [2:0]  win_idx;
    logic [7:0]  src_x;
    logic [6:0]  src_y;
    logic [2:0]  src_col;
    logic        src_out;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (CLOCK_50),
        .rst_n     (resetn),
        .req       (req),
        .advance   (arb_advance),
        .win_valid (win_valid),
        .win_idx   (win_idx)
    );

    // Pixel source and colour of the current winner, plus its on-screen check
    always_comb begin
        src_x   = pos_x(p1);
        src_y   = pos_y(p1);
        src_col = COL_P1;
        case (win_idx)
            REQ_P2: begin
                src_x   = pos_x(p2);
                src_y   = pos_y(p2);
                src_col = COL_P2;
            end
            REQ_P3: begin
                src_x   = pos_x(p3);
                src_y   = pos_y(p3);
                src_col = COL_P3;
            end
            REQ_P4: begin
                src_x   = pos_x(p4);
                src_y   = pos_y(p4);
                src_col = COL_P4;
            end
            REQ_TIMER: begin
                src_x   = timer_x;
                src_y   = TIMER_R;
                src_col = COL_TIMER;
            end
            default: ;
        endcase
        src_out = (int'(src_x) >= SCREEN_W) || (int'(src_y) >= SCREEN_H);
    end

    // Next state and next output registers; pixel (0,0) leaves with the clear request itself
    always_comb begin
        state_d     = state_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        x_d         = x_q;
        y_d         = y_q;
        colour_d    = colour_q;
        plot_d      = 1'b0;
        grant_d     = '0;
        busy_d      = 1'b0;
        dropped_d   = 1'b0;
        arb_advance = 1'b0;
        case (state_q)
            ST_ARB: begin
                // busy_q still high here only while the last sweep pixel is on the port
                if (clear_req && !busy_q) begin
                    state_d  = ST_CLEAR;
                    x_d      = '0;
                    y_d      = '0;
                    colour_d = COL_BLACK;
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                    sx_d     = 8'd1;
                    sy_d     = '0;
                end else if (win_valid) begin
                    arb_advance = 1'b1;
                    grant_d     = 5'b00001 << win_idx;
                    x_d         = src_x;
                    y_d         = src_y;
                    colour_d    = src_col;
                    plot_d      = !src_out;
                    dropped_d   = src_out;
                end
            end
            ST_CLEAR: begin
                x_d      = sx_q;
                y_d      = sy_q;
                colour_d = COL_BLACK;
                plot_d   = 1'b1;
                busy_d   = 1'b1;
                if (sx_q == X_LAST) begin
                    sx_d = '0;
                    if (sy_q == Y_LAST) begin
                        sy_d    = '0;
                        state_d = ST_ARB;
                    end else begin
                        sy_d = sy_q + 7'd1;
                    end
                end else begin
                    sx_d = sx_q + 8'd1;
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    // State, sweep counters and registered plot-port outputs
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_ARB;
            sx_q      <= '0;
            sy_q      <= '0;
            x_q       <= '0;
            y_q       <= '0;
            colour_q  <= COL_BLACK;
            plot_q    <= 1'b0;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sx_q      <= sx_d;
            sy_q      <= sy_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            plot_q    <= plot_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            dropped_q <= dropped_d;
        end
    end

    assign grant      = grant_q;
    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign clear_busy = busy_q;
    assign dropped    = dropped_q;

endmodule
